// File: rtl/kanade_pipe_pkg.sv
// Shared constants for the kanade32 pipeline: payload widths, the bit positions
// of the decode-control vector, and the occupancy encoding used by
// pipe_stage_reg.
package kanade_pipe_pkg;

    // Payload field widths.
    localparam int KW_DATA = 32;
    localparam int KW_INS  = 32;
    localparam int KW_PC   = 32;
    localparam int KW_REG  = 5;

    // Decode-control vector width. An all-zero vector is a NOP/bubble.
    localparam int KW_CTRL = 16;

    // Bit positions inside the decode-control vector.
    localparam int CTL_ALU_SRC       = 0;
    localparam int CTL_MEM_TO_REG    = 1;
    localparam int CTL_REG_WRITE     = 2;
    localparam int CTL_MEM_READ      = 3;
    localparam int CTL_MEM_WRITE     = 4;
    localparam int CTL_BRANCH        = 5;
    localparam int CTL_JMP           = 6;
    localparam int CTL_ALU_OP        = 7;   // LSB of the 3-bit ALU op field [9:7]
    localparam int CTL_ALU_OP_W      = 3;
    localparam int CTL_ALU_RES_TO_PC = 10;
    localparam int CTL_PC_TO_RA      = 11;

    // Stage occupancy: no beat, main entry only, main plus skid entry.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/pipe_stage_entry.sv
// One storage slot of a pipeline stage: a W-bit register with a load enable
// and a synchronous clear. The clear takes priority over the load.
module pipe_stage_entry
    import kanade_pipe_pkg::*;
#(
    parameter int W = KW_DATA + KW_CTRL
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    // Hold the slot contents; clear wins, otherwise capture on load.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            data_q <= '0;
        end else if (ld_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register for the kanade32 IF/ID/EX/MEM/WB boundaries.
// Carries a DATA_W payload and a CTRL_W decode-control vector. SKID=1 adds a
// second slot so in_ready comes straight from a flop; SKID=0 keeps one slot
// and a combinational in_ready. Flush kills every held beat.
// Build option: define PIPE_STAGE_PERF_EN to add the stall_cnt/bubble_cnt
// saturating performance counters.
//
// Handshake: a beat moves on a side only in a cycle where both valid and ready
// are high (accept = in_valid & in_ready, emit = out_valid & out_ready); valid
// never depends on ready on the same side, and a presented beat stays
// bit-stable until it is emitted or flushed.
module pipe_stage_reg
    import kanade_pipe_pkg::*;
#(
    parameter int DATA_W = KW_DATA,
    parameter int CTRL_W = KW_CTRL,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       bubble_cnt,
`endif
    output logic [1:0]        dbg_state_o
);

    localparam int EW = DATA_W + CTRL_W;

    pipe_state_e   state_q, state_d;
    logic          rst_done_q;
    logic          accept, emit;
    logic          main_ld, skid_ld, main_from_skid;
    logic [EW-1:0] main_q, main_d, skid_q;

    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign emit      = out_valid & out_ready;

    // Next occupancy and slot loads. Flush overrides everything: held beats
    // and any beat accepted this cycle are dropped, while a beat emitted this
    // cycle has already been taken downstream.
    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_ld = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && emit) begin
                        main_ld = 1'b1;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_ld = 1'b1;
                    end else if (emit) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (emit) begin
                        state_d        = ST_ONE;
                        main_ld        = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Occupancy register plus a flag that keeps in_ready low until the first
    // clock after reset is released.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_EMPTY;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;

            // Registered ready: open whenever the next occupancy leaves room,
            // so out_ready never reaches in_ready combinationally.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    rdy_q <= 1'b0;
                end else begin
                    rdy_q <= (state_d != ST_FULL);
                end
            end

            pipe_stage_entry #(.W(EW)) u_skid (
                .clk   (clk),
                .clr_i (!reset_n),
                .ld_i  (skid_ld),
                .d_i   ({in_ctrl, in_data}),
                .q_o   (skid_q)
            );

            // Flush also opens the input so upstream can drain the redirect;
            // flush is a redirect command, not part of the downstream ready path.
            assign in_ready = rdy_q | (flush & rst_done_q);
        end else begin : g_no_skid
            assign skid_q   = '0;
            assign in_ready = rst_done_q & (flush | !out_valid | out_ready);
        end
    endgenerate

    assign main_d = main_from_skid ? skid_q : {in_ctrl, in_data};

    pipe_stage_entry #(.W(EW)) u_main (
        .clk   (clk),
        .clr_i (!reset_n),
        .ld_i  (main_ld),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    // out_data keeps the last loaded payload when empty; control reads as a
    // bubble whenever nothing valid is presented.
    assign out_data    = main_q[DATA_W-1:0];
    assign out_ctrl    = out_valid ? main_q[EW-1:DATA_W] : '0;
    assign dbg_state_o = state_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q, bubble_cnt_q;

    // Saturating counts of downstream stalls and idle-but-ready cycles;
    // flush leaves them alone.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (!out_valid && out_ready && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one instance with SKID=0 (lane 0) and one with
// SKID=1 (lane 1) share the same input stimulus. The reference model treats
// each stage as a FIFO of pending beats with capacity 1 (SKID=0) or 2
// (SKID=1), emptied by flush.
module tb_pipe_stage_reg;

    localparam int DW = 32;
    localparam int CW = 16;
    localparam int EW = DW + CW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;

    logic          rdy_w [2];
    logic          ov_w  [2];
    logic [DW-1:0] od_w  [2];
    logic [CW-1:0] oc_w  [2];
    logic [1:0]    st_w  [2];
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   sc_w  [2];
    logic [31:0]   bc_w  [2];
    bit            sat_req = 1'b0;
`endif

    for (genvar g = 0; g < 2; g++) begin : lane
        pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(g)) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .flush       (flush),
            .in_valid    (in_valid),
            .in_ready    (rdy_w[g]),
            .in_data     (in_data),
            .in_ctrl     (in_ctrl),
            .out_valid   (ov_w[g]),
            .out_ready   (out_ready),
            .out_data    (od_w[g]),
            .out_ctrl    (oc_w[g]),
`ifdef PIPE_STAGE_PERF_EN
            .stall_cnt   (sc_w[g]),
            .bubble_cnt  (bc_w[g]),
`endif
            .dbg_state_o (st_w[g])
        );
    end

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q [2][$];
    logic [DW-1:0] last_head [2] = '{32'd0, 32'd0};
    bit            last_rst = 1'b1;
    int            errors = 0;
    int            checks = 0;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0]   exp_stall [2] = '{32'd0, 32'd0};
    logic [31:0]   exp_bub   [2] = '{32'd0, 32'd0};
`endif

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d(SKID=%0d) t=%0t: got %0h, expected %0h", name, k, k, $time, act, exp);
        end
    endtask

    // Monitor: outputs are sampled at negedge, compared with the model, then the
    // model applies the accept/emit/flush that the coming posedge will perform.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int   sz;
            logic exp_rdy;
            logic acc;
            logic emt;
            sz = exp_q[k].size();
            if (last_rst) exp_rdy = 1'b0;
            else if (k == 1) exp_rdy = (sz < 2) || flush;
            else exp_rdy = (sz == 0) || out_ready || flush;

            if (last_rst) begin
                chk("rst_out_valid", k, 64'(ov_w[k]), 64'd0);
                chk("rst_out_ctrl", k, 64'(oc_w[k]), 64'd0);
                chk("rst_out_data", k, 64'(od_w[k]), 64'd0);
                chk("rst_state", k, 64'(st_w[k]), 64'd0);
            end else begin
                chk("out_valid", k, 64'(ov_w[k]), 64'(sz > 0));
                chk("state", k, 64'(st_w[k]), 64'(sz));
                if (sz > 0) begin
                    chk("payload", k, 64'({oc_w[k], od_w[k]}), 64'(exp_q[k][0]));
                    last_head[k] = exp_q[k][0][DW-1:0];
                end else begin
                    chk("idle_ctrl", k, 64'(oc_w[k]), 64'd0);
                    chk("idle_data_kept", k, 64'(od_w[k]), 64'(last_head[k]));
                end
            end
            chk("in_ready", k, 64'(rdy_w[k]), 64'(exp_rdy));
`ifdef PIPE_STAGE_PERF_EN
            if (k == 1 && sat_req) exp_stall[1] = 32'hFFFF_FFFF;
            chk("stall_cnt", k, 64'(sc_w[k]), 64'(exp_stall[k]));
            chk("bubble_cnt", k, 64'(bc_w[k]), 64'(exp_bub[k]));
`endif

            if (!reset_n) begin
                exp_q[k].delete();
                last_head[k] = '0;
`ifdef PIPE_STAGE_PERF_EN
                exp_stall[k] = '0;
                exp_bub[k]   = '0;
`endif
            end else begin
                acc = in_valid && exp_rdy;
                emt = (sz > 0) && out_ready;
`ifdef PIPE_STAGE_PERF_EN
                if (sz > 0 && !out_ready && exp_stall[k] != '1) exp_stall[k] = exp_stall[k] + 1;
                if (sz == 0 && out_ready && exp_bub[k] != '1) exp_bub[k] = exp_bub[k] + 1;
`endif
                if (emt) void'(exp_q[k].pop_front());
                if (flush) exp_q[k].delete();
                else if (acc) exp_q[k].push_back({in_ctrl, in_data});
            end
        end
        last_rst = !reset_n;
    end

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset held for three clocks while upstream offers a beat.
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hDEAD_BEEF;
        in_ctrl   = 16'h0FF0;
        out_ready = 1'b1;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #2;
        idle(2);

        // Back-to-back streaming 1..8 with downstream always ready.
        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), CW'(i), 1'b1, 1'b0);
        idle(2);

        // Two beats into a stalled stage, hold the stall, then flush with C.
        step(1'b1, 32'h0000_000A, 16'h00A1, 1'b0, 1'b0);
        step(1'b1, 32'h0000_000B, 16'h00B2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_000C, 16'h00C3, 1'b0, 1'b1);
        step(1'b1, 32'h0000_000D, 16'h00D4, 1'b1, 1'b0);
        idle(2);

        // Stall with two beats held, then drain in order.
        step(1'b1, 32'h1111_000A, 16'h01A1, 1'b0, 1'b0);
        step(1'b1, 32'h1111_000B, 16'h01B2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
        idle(3);

        // Flush in the same cycle the held beat is emitted.
        step(1'b1, 32'h2222_000E, 16'h02E5, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        idle(1);
        step(1'b1, 32'h3333_000F, 16'h03F6, 1'b0, 1'b0);
        step(1'b1, 32'h3333_0010, 16'h0307, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b1);
        idle(2);

`ifdef PIPE_STAGE_PERF_EN
        // Stall cycles, idle cycles, then a stall counter pinned at all-ones.
        step(1'b1, 32'h4444_0001, 16'h0411, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
        idle(3);
        step(1'b1, 32'h4444_0002, 16'h0422, 1'b0, 1'b0);
        force lane[1].u_dut.stall_cnt_q = 32'hFFFF_FFFF;
        sat_req = 1'b1;
        #1;
        release lane[1].u_dut.stall_cnt_q;
        step(1'b0, '0, '0, 1'b0, 1'b0);
        sat_req = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
        idle(2);
`endif

        // Randomized traffic with occasional stalls and flushes.
        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 3) != 0, $urandom, CW'($urandom),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
        end
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
